// File: rtl/softmax_input_loader.sv
`default_nettype none
// ============================================================================
// Module  : softmax_input_loader
// Brief   : Streams NUM-lane vectors into the softmax input memory, pulses the
//           core init/start, then measures the core's done window.
//           Optional macro SOFTMAX_LOADER_TIMEOUT_EN adds a WAIT-state timeout.
// Rev     : 1.0 - initial release
// ============================================================================

module softmax_input_loader #(
  parameter int DATAWIDTH = 16,
  parameter int NUM       = 4,
  parameter int ADDRSIZE  = 8
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
  ,
  parameter int TIMEOUT   = 4096
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      go,
  input  logic [ADDRSIZE-1:0]       cfg_start_addr,
  input  logic [ADDRSIZE:0]         cfg_len,
  input  logic                      s_valid,
  input  logic [DATAWIDTH*NUM-1:0]  s_data,
  output logic                      s_ready,
  output logic                      mem_we,
  output logic [ADDRSIZE-1:0]       mem_waddr,
  output logic [DATAWIDTH*NUM-1:0]  mem_wdata,
  output logic [ADDRSIZE-1:0]       sm_start_addr,
  output logic [ADDRSIZE-1:0]       sm_end_addr,
  output logic                      sm_init,
  output logic                      sm_start,
  input  logic                      sm_done,
  output logic                      busy,
  output logic                      complete,
  output logic                      cfg_err,
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
  output logic                      timeout,
`endif
  output logic [ADDRSIZE:0]         out_beats
);

  localparam int                c_word_w   = DATAWIDTH * NUM;
  localparam logic [ADDRSIZE:0] c_one      = 1;
  localparam logic [ADDRSIZE:0] c_beat_max = {1'b1, {ADDRSIZE{1'b0}}};

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_INIT  = 3'd2,
    ST_START = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_s_ready, w_s_ready_nxt;
  logic                  r_mem_we, w_mem_we_nxt;
  logic [ADDRSIZE-1:0]   r_mem_waddr, w_mem_waddr_nxt;
  logic [c_word_w-1:0]   r_mem_wdata, w_mem_wdata_nxt;
  logic [ADDRSIZE-1:0]   r_sm_start_addr, w_sm_start_addr_nxt;
  logic [ADDRSIZE-1:0]   r_sm_end_addr, w_sm_end_addr_nxt;
  logic                  r_sm_init, w_sm_init_nxt;
  logic                  r_sm_start, w_sm_start_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_complete, w_complete_nxt;
  logic                  r_cfg_err, w_cfg_err_nxt;
  logic [ADDRSIZE:0]     r_out_beats, w_out_beats_nxt;
  logic [ADDRSIZE:0]     r_count, w_count_nxt;
  logic [ADDRSIZE:0]     r_len, w_len_nxt;
  logic                  r_armed, w_armed_nxt;
  logic                  r_seen_high, w_seen_high_nxt;

`ifdef SOFTMAX_LOADER_TIMEOUT_EN
  localparam int                c_to_w    = $clog2(TIMEOUT + 1);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);
  localparam logic [c_to_w-1:0] c_to_one  = 1;
  logic [c_to_w-1:0]     r_wait_cnt, w_wait_cnt_nxt;
  logic                  r_timeout, w_timeout_nxt;
`endif

  // End address computed one bit wider so a wrap past the top shows up in the MSB
  logic [ADDRSIZE:0]     w_cfg_end;
  logic                  w_cfg_bad;
  logic                  w_accept;
  logic                  w_last;
  logic                  w_window_done;

  assign w_cfg_end     = {1'b0, cfg_start_addr} + cfg_len - c_one;
  assign w_cfg_bad     = (cfg_len == '0) || w_cfg_end[ADDRSIZE];
  assign w_accept      = r_s_ready & s_valid;
  assign w_last        = (r_count == (r_len - c_one));
  assign w_window_done = r_seen_high & ~sm_done;

  always_comb begin
    w_state_nxt         = r_state;
    w_s_ready_nxt       = r_s_ready;
    w_mem_we_nxt        = 1'b0;
    w_mem_waddr_nxt     = r_mem_waddr;
    w_mem_wdata_nxt     = r_mem_wdata;
    w_sm_start_addr_nxt = r_sm_start_addr;
    w_sm_end_addr_nxt   = r_sm_end_addr;
    w_sm_init_nxt       = 1'b0;
    w_sm_start_nxt      = 1'b0;
    w_busy_nxt          = r_busy;
    w_complete_nxt      = 1'b0;
    w_cfg_err_nxt       = 1'b0;
    w_out_beats_nxt     = r_out_beats;
    w_count_nxt         = r_count;
    w_len_nxt           = r_len;
    w_armed_nxt         = r_armed;
    w_seen_high_nxt     = r_seen_high;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
    w_wait_cnt_nxt      = r_wait_cnt;
    w_timeout_nxt       = 1'b0;
`endif

    case (r_state)
      ST_IDLE: begin
        // The cycle showing complete is already IDLE, but go there belongs to the old job
        if (go && !r_complete) begin
          if (w_cfg_bad) begin
            w_cfg_err_nxt = 1'b1;
          end else begin
            w_sm_start_addr_nxt = cfg_start_addr;
            w_sm_end_addr_nxt   = w_cfg_end[ADDRSIZE-1:0];
            w_len_nxt           = cfg_len;
            w_count_nxt         = '0;
            w_out_beats_nxt     = '0;
            w_busy_nxt          = 1'b1;
            w_s_ready_nxt       = 1'b1;
            w_state_nxt         = ST_LOAD;
          end
        end
      end

      ST_LOAD: begin
        if (w_accept) begin
          w_mem_we_nxt    = 1'b1;
          w_mem_waddr_nxt = r_sm_start_addr + r_count[ADDRSIZE-1:0];
          w_mem_wdata_nxt = s_data;
          w_count_nxt     = r_count + c_one;
          if (w_last) begin
            w_s_ready_nxt = 1'b0;
            w_state_nxt   = ST_INIT;
          end
        end
      end

      ST_INIT: begin
        w_sm_init_nxt = 1'b1;
        w_state_nxt   = ST_START;
      end

      ST_START: begin
        w_sm_start_nxt  = 1'b1;
        w_armed_nxt     = 1'b0;
        w_seen_high_nxt = 1'b0;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
        w_wait_cnt_nxt  = '0;
`endif
        w_state_nxt     = ST_WAIT;
      end

      ST_WAIT: begin
        // A done level left over from a previous job only counts after a low cycle
        if (sm_done) begin
          if (r_armed) begin
            w_seen_high_nxt = 1'b1;
            if (r_out_beats != c_beat_max) begin
              w_out_beats_nxt = r_out_beats + c_one;
            end
          end
        end else begin
          w_armed_nxt = 1'b1;
        end

        if (w_window_done) begin
          w_complete_nxt = 1'b1;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
        end
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
        else if (r_wait_cnt == c_to_last) begin
          w_timeout_nxt  = 1'b1;
          w_complete_nxt = 1'b1;
          w_busy_nxt     = 1'b0;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + c_to_one;
        end
`endif
      end

      default: begin
        w_s_ready_nxt = 1'b0;
        w_busy_nxt    = 1'b0;
        w_state_nxt   = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= ST_IDLE;
      r_s_ready       <= 1'b0;
      r_mem_we        <= 1'b0;
      r_mem_waddr     <= '0;
      r_mem_wdata     <= '0;
      r_sm_start_addr <= '0;
      r_sm_end_addr   <= '0;
      r_sm_init       <= 1'b0;
      r_sm_start      <= 1'b0;
      r_busy          <= 1'b0;
      r_complete      <= 1'b0;
      r_cfg_err       <= 1'b0;
      r_out_beats     <= '0;
      r_count         <= '0;
      r_len           <= '0;
      r_armed         <= 1'b0;
      r_seen_high     <= 1'b0;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
      r_wait_cnt      <= '0;
      r_timeout       <= 1'b0;
`endif
    end else begin
      r_state         <= w_state_nxt;
      r_s_ready       <= w_s_ready_nxt;
      r_mem_we        <= w_mem_we_nxt;
      r_mem_waddr     <= w_mem_waddr_nxt;
      r_mem_wdata     <= w_mem_wdata_nxt;
      r_sm_start_addr <= w_sm_start_addr_nxt;
      r_sm_end_addr   <= w_sm_end_addr_nxt;
      r_sm_init       <= w_sm_init_nxt;
      r_sm_start      <= w_sm_start_nxt;
      r_busy          <= w_busy_nxt;
      r_complete      <= w_complete_nxt;
      r_cfg_err       <= w_cfg_err_nxt;
      r_out_beats     <= w_out_beats_nxt;
      r_count         <= w_count_nxt;
      r_len           <= w_len_nxt;
      r_armed         <= w_armed_nxt;
      r_seen_high     <= w_seen_high_nxt;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
      r_wait_cnt      <= w_wait_cnt_nxt;
      r_timeout       <= w_timeout_nxt;
`endif
    end
  end

  assign s_ready       = r_s_ready;
  assign mem_we        = r_mem_we;
  assign mem_waddr     = r_mem_waddr;
  assign mem_wdata     = r_mem_wdata;
  assign sm_start_addr = r_sm_start_addr;
  assign sm_end_addr   = r_sm_end_addr;
  assign sm_init       = r_sm_init;
  assign sm_start      = r_sm_start;
  assign busy          = r_busy;
  assign complete      = r_complete;
  assign cfg_err       = r_cfg_err;
  assign out_beats     = r_out_beats;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
  assign timeout       = r_timeout;
`endif

endmodule

`default_nettype wire

// File: tb/tb_softmax_input_loader.sv
`default_nettype none
// Bench for softmax_input_loader: a job-level reference model compared every
// cycle, plus hand-computed literal checks per directed scenario.

module tb_softmax_input_loader;

  localparam int AW  = 8;
  localparam int TO  = 16;
  localparam int M_IDLE = 0, M_LOAD = 1, M_HS = 2, M_WAIT = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            go = 1'b0;
  logic [AW-1:0]   cfg_start_addr = '0;
  logic [AW:0]     cfg_len = '0;
  logic            s_valid = 1'b0;
  logic [63:0]     s_data = '0;
  logic            s_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_waddr;
  logic [63:0]     mem_wdata;
  logic [AW-1:0]   sm_start_addr;
  logic [AW-1:0]   sm_end_addr;
  logic            sm_init;
  logic            sm_start;
  logic            sm_done = 1'b0;
  logic            busy;
  logic            complete;
  logic            cfg_err;
  logic [AW:0]     out_beats;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
  logic            timeout;
`endif

  softmax_input_loader #(
    .DATAWIDTH(16),
    .NUM(4),
    .ADDRSIZE(AW)
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
    ,
    .TIMEOUT(TO)
`endif
  ) dut (
    .clk(clk), .reset(reset), .go(go),
    .cfg_start_addr(cfg_start_addr), .cfg_len(cfg_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .sm_start_addr(sm_start_addr), .sm_end_addr(sm_end_addr),
    .sm_init(sm_init), .sm_start(sm_start), .sm_done(sm_done),
    .busy(busy), .complete(complete), .cfg_err(cfg_err),
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
    .timeout(timeout),
`endif
    .out_beats(out_beats)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (job-level view) ----------------
  int            m_mode = M_IDLE;
  int            m_len = 0, m_taken = 0, m_hs = 0;
  bit            hist[$];
  bit            was_complete;
  int            m_last, m_n;
  bit            m_fin;
  logic          exp_s_ready = 0, exp_mem_we = 0, exp_init = 0, exp_start = 0;
  logic          exp_busy = 0, exp_complete = 0, exp_cfg_err = 0, exp_timeout = 0;
  logic [AW-1:0] exp_waddr = '0, exp_sa = '0, exp_ea = '0;
  logic [63:0]   exp_wdata = '0;
  logic [AW:0]   exp_beats = '0;

  // Done history since WAIT entry: stale leading highs, then lows, then the window.
  function automatic void done_eval(output int n, output bit fin);
    int i = 0;
    n = 0;
    while (i < hist.size() && hist[i]) i++;
    while (i < hist.size() && !hist[i]) i++;
    while (i < hist.size() && hist[i]) begin n++; i++; end
    fin = (i < hist.size()) && (n > 0);
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_len = 0; m_taken = 0; m_hs = 0; hist.delete();
      exp_s_ready = 0; exp_mem_we = 0; exp_init = 0; exp_start = 0; exp_busy = 0;
      exp_complete = 0; exp_cfg_err = 0; exp_timeout = 0;
      exp_waddr = '0; exp_sa = '0; exp_ea = '0; exp_wdata = '0; exp_beats = '0;
    end else begin
      was_complete = exp_complete;
      exp_mem_we = 0; exp_init = 0; exp_start = 0; exp_complete = 0;
      exp_cfg_err = 0; exp_timeout = 0;
      case (m_mode)
        M_IDLE: if (go && !was_complete) begin
          m_last = int'(cfg_start_addr) + int'(cfg_len) - 1;
          if (cfg_len == 0 || m_last > (1 << AW) - 1) exp_cfg_err = 1;
          else begin
            exp_sa = cfg_start_addr; exp_ea = AW'(m_last);
            m_len = int'(cfg_len); m_taken = 0; exp_beats = '0;
            exp_busy = 1; m_mode = M_LOAD;
          end
        end
        M_LOAD: if (s_valid && exp_s_ready) begin
          exp_mem_we = 1; exp_waddr = exp_sa + AW'(m_taken); exp_wdata = s_data;
          m_taken++;
          if (m_taken == m_len) begin m_mode = M_HS; m_hs = 0; end
        end
        M_HS: begin
          m_hs++;
          if (m_hs == 1) exp_init = 1;
          else begin exp_start = 1; m_mode = M_WAIT; hist.delete(); end
        end
        default: begin
          hist.push_back(sm_done);
          done_eval(m_n, m_fin);
          exp_beats = (m_n > (1 << AW)) ? (AW+1)'(1 << AW) : (AW+1)'(m_n);
          if (m_fin) begin
            exp_complete = 1; exp_busy = 0; m_mode = M_IDLE;
          end
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
          else if (hist.size() == TO) begin
            exp_timeout = 1; exp_complete = 1; exp_busy = 0; m_mode = M_IDLE;
          end
`endif
        end
      endcase
      exp_s_ready = (m_mode == M_LOAD) && (m_taken < m_len);
    end
  end

  always @(negedge clk) begin
    if (reset && check_en) begin
      chk("s_ready", s_ready, exp_s_ready);
      chk("mem_we", mem_we, exp_mem_we);
      if (exp_mem_we) begin
        chk("mem_waddr", mem_waddr, exp_waddr);
        chk("mem_wdata", mem_wdata, exp_wdata);
      end
      chk("sm_start_addr", sm_start_addr, exp_sa);
      chk("sm_end_addr", sm_end_addr, exp_ea);
      chk("sm_init", sm_init, exp_init);
      chk("sm_start", sm_start, exp_start);
      chk("busy", busy, exp_busy);
      chk("complete", complete, exp_complete);
      chk("cfg_err", cfg_err, exp_cfg_err);
      chk("out_beats", out_beats, exp_beats);
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
      chk("timeout", timeout, exp_timeout);
`endif
    end
  end

  // ---------------- observation of DUT results ----------------
  logic [63:0] img [0:255];
  int wr_count = 0, n_complete = 0, n_cfg_err = 0, n_timeout = 0;
  int cyc = 0, t_init = 0, t_start = 0, t_complete = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin img[mem_waddr] = mem_wdata; wr_count++; end
      if (complete) begin n_complete++; t_complete = cyc; end
      if (cfg_err) n_cfg_err++;
      if (sm_init) t_init = cyc;
      if (sm_start) t_start = cyc;
`ifdef SOFTMAX_LOADER_TIMEOUT_EN
      if (timeout) n_timeout++;
`endif
    end
    cyc++;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [63:0] dat(input int tag, input int k);
    return {16'(tag), 16'(k), 16'hBEEF, 16'(tag * 16 + k)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int sa, input int len);
    go = 1; cfg_start_addr = AW'(sa); cfg_len = (AW+1)'(len);
    step();
    go = 0;
  endtask

  task automatic send_beats(input int tag, input int n);
    for (int k = 0; k < n; k++) begin
      s_valid = 1; s_data = dat(tag, k);
      step();
    end
    s_valid = 0;
  endtask

  task automatic wait_entry();
    for (int i = 0; i < 64; i++) begin
      if (m_mode == M_WAIT) break;
      step();
    end
    if (m_mode != M_WAIT) begin
      checks++; failures++;
      $display("FAIL wait_entry actual=mode%0d expected=wait", m_mode);
    end
  endtask

  task automatic drive_done(input logic [15:0] pat, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      sm_done = pat[i];
      step();
    end
    sm_done = 0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      if (m_mode == M_IDLE) break;
      step();
    end
    if (m_mode != M_IDLE) begin
      checks++; failures++;
      $display("FAIL wait_idle actual=mode%0d expected=idle", m_mode);
    end
    step(); step();
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  int wr0, c0, e0;

  initial begin
    // Reset state
    step(); step();
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_out_beats", out_beats, 0);
    #2 reset = 1;
    check_en = 1;
    step();

    // Single job, no stalls
    c0 = n_complete;
    start_job(8, 4);
    chk("t1_end_addr", sm_end_addr, 11);
    send_beats(1, 4);
    wait_entry();
    drive_done(16'b011110, 6);
    wait_idle();
    for (int k = 0; k < 4; k++) chk("t1_mem", img[8 + k], dat(1, k));
    chk("t1_out_beats", out_beats, 4);
    chk("t1_complete_cnt", n_complete - c0, 1);
    chk("t1_init_to_start", t_start - t_init, 1);

    // Backpressure: valid 1,0,0,1,0,1 then extra valid beats that must not be taken
    wr0 = wr_count;
    start_job(40, 3);
    for (int k = 0; k < 8; k++) begin
      s_valid = (k == 0 || k == 3 || k >= 5);
      s_data = dat(2, k);
      step();
    end
    s_valid = 0;
    wait_entry();
    drive_done(16'b010, 3);
    wait_idle();
    chk("t2_writes", wr_count - wr0, 3);
    chk("t2_mem0", img[40], dat(2, 0));
    chk("t2_mem1", img[41], dat(2, 3));
    chk("t2_mem2", img[42], dat(2, 5));
    chk("t2_out_beats", out_beats, 1);

    // Config errors and the top-of-memory boundary
    wr0 = wr_count; e0 = n_cfg_err;
    start_job(5, 0);
    chk("t3_len0_err", cfg_err, 1);
    chk("t3_len0_busy", busy, 0);
    step();
    start_job(250, 10);
    chk("t3_wrap_err", cfg_err, 1);
    step();
    chk("t3_err_cnt", n_cfg_err - e0, 2);
    chk("t3_no_writes", wr_count - wr0, 0);
    start_job(246, 10);
    chk("t3_end_addr", sm_end_addr, 255);
    chk("t3_busy", busy, 1);
    send_beats(3, 10);
    wait_entry();
    drive_done(16'b01110, 5);
    wait_idle();
    chk("t3_mem_first", img[246], dat(3, 0));
    chk("t3_mem_last", img[255], dat(3, 9));
    chk("t3_out_beats", out_beats, 3);

    // Busy guard and stale done
    c0 = n_complete;
    start_job(60, 2);
    s_valid = 1; s_data = dat(4, 0);
    step();
    go = 1; cfg_start_addr = 0; cfg_len = 1; s_data = dat(4, 1);
    step();
    go = 0; s_valid = 0; sm_done = 1;
    wait_entry();
    go = 1; sm_done = 1;
    step();
    go = 0;
    drive_done(16'b0110, 4);
    wait_idle();
    chk("t4_out_beats", out_beats, 2);
    chk("t4_start_addr", sm_start_addr, 60);
    chk("t4_end_addr", sm_end_addr, 61);
    chk("t4_complete_cnt", n_complete - c0, 1);

    // Async reset mid-LOAD, then a clean job
    c0 = n_complete;
    start_job(120, 5);
    send_beats(5, 2);
    #2 reset = 0;
    #1;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_s_ready", s_ready, 0);
    chk("t5_rst_mem_we", mem_we, 0);
    chk("t5_rst_start_addr", sm_start_addr, 0);
    chk("t5_rst_end_addr", sm_end_addr, 0);
    step();
    reset = 1;
    step();
    start_job(200, 2);
    send_beats(6, 2);
    wait_entry();
    drive_done(16'b010, 3);
    wait_idle();
    chk("t5_mem0", img[200], dat(6, 0));
    chk("t5_mem1", img[201], dat(6, 1));
    chk("t5_end_addr", sm_end_addr, 201);
    chk("t5_complete_cnt", n_complete - c0, 1);

`ifdef SOFTMAX_LOADER_TIMEOUT_EN
    // WAIT timeout with done never asserted
    start_job(10, 1);
    send_beats(7, 1);
    wait_entry();
    wait_idle();
    chk("t6_timeout_cnt", n_timeout, 1);
    chk("t6_timeout_delay", t_complete - t_start, TO);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
